vector_apply_capture: RTL and testbench

Synthesizable stimulus/response sequencer for combinational benchmark circuits (ISCAS-class DUTs). It fetches stimulus and expected-response words from an external vector memory and applies each stimulus to the DUT. After a programmable settle time it captures the DUT output and streams each result out over a ready/valid handshake. It also maintains a mismatch count and a MISR signature, so a full regression run produces a single pass/fail summary without file I/O.

---
 rtl/vec_harness_pkg.sv | 39 +++
 rtl/misr_reg.sv | 29 ++
 rtl/vector_apply_capture.sv | 166 ++++++++++++++++
 tb/tb_vector_apply_capture.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_harness_pkg.sv
// Shared types and helpers for the vector apply/capture sequencer.
// Holds the sequencer state encoding and the MISR step function.
package vec_harness_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    APPLY = 3'd2,
    EMIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [31:0] DEFAULT_MISR_POLY = 32'h04C1_1DB7;
  localparam int          MISR_MAX_W        = 64;

  // Width-generic MISR step; operands are zero-extended to MISR_MAX_W and the
  // result is masked back to 'width' bits so the caller can truncate safely.
  function automatic logic [MISR_MAX_W-1:0] misr_step(
    input logic [MISR_MAX_W-1:0] sig,
    input logic [MISR_MAX_W-1:0] data,
    input logic [MISR_MAX_W-1:0] poly,
    input int unsigned           width
  );
    logic [MISR_MAX_W-1:0] mask;
    logic [MISR_MAX_W-1:0] fb;
    if (width >= 32'd64) begin
      mask = {MISR_MAX_W{1'b1}};
    end else begin
      mask = (64'd1 << width) - 64'd1;
    end
    if (((sig >> (width - 32'd1)) & 64'd1) != 64'd0) begin
      fb = poly;
    end else begin
      fb = {MISR_MAX_W{1'b0}};
    end
    return ((sig << 1) ^ fb ^ data) & mask;
  endfunction

endpackage

// File: rtl/misr_reg.sv
// Multiple-input signature register compacting captured responses.
module misr_reg
  import vec_harness_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEFAULT_MISR_POLY)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] sig
);

  always_ff @(posedge clk) begin
    if (rst) begin
      sig <= {WIDTH{1'b0}};
    end else if (clear) begin
      sig <= {WIDTH{1'b0}};
    end else if (en) begin
      sig <= WIDTH'(misr_step(MISR_MAX_W'(sig), MISR_MAX_W'(data),
                              MISR_MAX_W'(POLY), WIDTH));
    end else begin
      sig <= sig;
    end
  end

endmodule

// File: rtl/vector_apply_capture.sv
// Stimulus/response sequencer: fetch vector, drive DUT, wait settle time,
// capture and stream the response, tracking mismatches and a MISR signature.
module vector_apply_capture
  import vec_harness_pkg::*;
#(
  parameter int                   IN_WIDTH      = 41,
  parameter int                   OUT_WIDTH     = 32,
  parameter int                   DEPTH         = 10000,
  parameter int                   SETTLE_CYCLES = 1,
  parameter logic [OUT_WIDTH-1:0] MISR_POLY     = OUT_WIDTH'(DEFAULT_MISR_POLY),
  localparam int                  AW            = $clog2(DEPTH),
  localparam int                  CW            = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CW-1:0]        num_tests,
  output logic [AW-1:0]        mem_addr,
  input  logic [IN_WIDTH-1:0]  mem_stim,
  input  logic [OUT_WIDTH-1:0] mem_exp,
  output logic [IN_WIDTH-1:0]  dut_in,
  input  logic [OUT_WIDTH-1:0] dut_out,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [OUT_WIDTH-1:0] res_data,
  output logic [AW-1:0]        res_index,
  output logic                 res_mismatch,
  output logic                 busy,
  output logic                 done,
  output logic [CW-1:0]        err_count,
  output logic [OUT_WIDTH-1:0] signature
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_t               state;
  state_t               state_nxt;
  logic [CW-1:0]        n_q;
  logic [AW-1:0]        index;
  logic [7:0]           settle_cnt;
  logic [OUT_WIDTH-1:0] exp_q;
  logic [CW-1:0]        n_lim;
  logic                 accept;
  logic                 last_settle;
  logic                 last_vec;
  logic                 capture;

  assign accept      = start && ((state == IDLE) || (state == DONE));
  assign n_lim       = (num_tests > CW'(DEPTH)) ? CW'(DEPTH) : num_tests;
  assign last_settle = (settle_cnt == SETTLE_LAST);
  assign last_vec    = (CW'(index) == (n_q - CW'(1)));
  assign capture     = (state == APPLY) && last_settle;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          state_nxt = (n_lim == {CW{1'b0}}) ? DONE : FETCH;
        end else begin
          state_nxt = state;
        end
      end
      FETCH: state_nxt = APPLY;
      APPLY: begin
        if (last_settle) begin
          state_nxt = EMIT;
        end else begin
          state_nxt = APPLY;
        end
      end
      EMIT: begin
        if (res_ready) begin
          state_nxt = last_vec ? DONE : FETCH;
        end else begin
          state_nxt = EMIT;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Status flags follow the next state so they are registered yet in step with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy         <= 1'b0;
      res_valid    <= 1'b0;
      done         <= 1'b0;
      n_q          <= {CW{1'b0}};
      index        <= {AW{1'b0}};
      mem_addr     <= {AW{1'b0}};
      settle_cnt   <= 8'd0;
      dut_in       <= {IN_WIDTH{1'b0}};
      exp_q        <= {OUT_WIDTH{1'b0}};
      res_data     <= {OUT_WIDTH{1'b0}};
      res_index    <= {AW{1'b0}};
      res_mismatch <= 1'b0;
      err_count    <= {CW{1'b0}};
    end else begin
      busy      <= (state_nxt == FETCH) || (state_nxt == APPLY) || (state_nxt == EMIT);
      res_valid <= (state_nxt == EMIT);
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            n_q       <= n_lim;
            index     <= {AW{1'b0}};
            mem_addr  <= {AW{1'b0}};
            err_count <= {CW{1'b0}};
            done      <= (n_lim == {CW{1'b0}});
          end
        end
        FETCH: begin
          settle_cnt <= 8'd0;
          dut_in     <= mem_stim;
          exp_q      <= mem_exp;
        end
        APPLY: begin
          if (last_settle) begin
            res_data     <= dut_out;
            res_index    <= index;
            res_mismatch <= (dut_out != exp_q);
            if ((dut_out != exp_q) && (err_count != {CW{1'b1}})) begin
              err_count <= err_count + CW'(1);
            end
          end else begin
            settle_cnt <= settle_cnt + 8'd1;
          end
        end
        EMIT: begin
          if (res_ready) begin
            if (last_vec) begin
              done <= 1'b1;
            end else begin
              index    <= index + AW'(1);
              mem_addr <= index + AW'(1);
            end
          end
        end
        default: begin
          done <= 1'b0;
        end
      endcase
    end
  end

  misr_reg #(
    .WIDTH (OUT_WIDTH),
    .POLY  (MISR_POLY)
  ) u_misr (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .en    (capture),
    .data  (dut_out),
    .sig   (signature)
  );

endmodule

// File: tb/tb_vector_apply_capture.sv
// Directed bench: one sequencer with an identity DUT (settle 1) and one with a
// two-cycle-delay DUT (settle 3), sharing a small vector memory.
module tb_vector_apply_capture;

  localparam int IW = 41;
  localparam int OW = 32;
  localparam int DP = 8;
  localparam int AW = 3;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [IW-1:0] stim   [DP];
  logic [OW-1:0] expw   [DP];
  logic [OW-1:0] exp_lo [DP];

  // instance A: identity DUT, settle 1
  logic          a_start = 1'b0, a_ready = 1'b1;
  logic [CW-1:0] a_num = '0;
  logic [AW-1:0] a_mem_addr, a_index;
  logic [IW-1:0] a_mem_stim, a_dut_in;
  logic [OW-1:0] a_mem_exp, a_dut_out, a_data, a_sig;
  logic          a_valid, a_mm, a_busy, a_done;
  logic [CW-1:0] a_err;
  assign a_mem_stim = stim[a_mem_addr];
  assign a_mem_exp  = expw[a_mem_addr];
  assign a_dut_out  = a_dut_in[31:0];

  vector_apply_capture #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .DEPTH(DP), .SETTLE_CYCLES(1)) u_dut_a (
    .clk(clk), .rst(rst), .start(a_start), .num_tests(a_num), .mem_addr(a_mem_addr),
    .mem_stim(a_mem_stim), .mem_exp(a_mem_exp), .dut_in(a_dut_in), .dut_out(a_dut_out),
    .res_valid(a_valid), .res_ready(a_ready), .res_data(a_data), .res_index(a_index),
    .res_mismatch(a_mm), .busy(a_busy), .done(a_done), .err_count(a_err), .signature(a_sig));

  // instance B: DUT with 2-cycle output delay, settle 3
  logic          b_start = 1'b0;
  logic [CW-1:0] b_num = '0;
  logic [AW-1:0] b_mem_addr, b_index;
  logic [IW-1:0] b_mem_stim, b_dut_in;
  logic [OW-1:0] b_mem_exp, b_dut_out, b_data, b_sig, b_d1, b_d2;
  logic          b_valid, b_mm, b_busy, b_done;
  logic [CW-1:0] b_err;
  assign b_mem_stim = stim[b_mem_addr];
  assign b_mem_exp  = expw[b_mem_addr];
  always @(posedge clk) begin
    b_d1 <= b_dut_in[31:0];
    b_d2 <= b_d1;
  end
  assign b_dut_out = b_d2;

  vector_apply_capture #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .DEPTH(DP), .SETTLE_CYCLES(3)) u_dut_b (
    .clk(clk), .rst(rst), .start(b_start), .num_tests(b_num), .mem_addr(b_mem_addr),
    .mem_stim(b_mem_stim), .mem_exp(b_mem_exp), .dut_in(b_dut_in), .dut_out(b_dut_out),
    .res_valid(b_valid), .res_ready(1'b1), .res_data(b_data), .res_index(b_index),
    .res_mismatch(b_mm), .busy(b_busy), .done(b_done), .err_count(b_err), .signature(b_sig));

  // result monitors
  logic [OW-1:0] qa_data[$];
  int            qa_idx[$];
  logic          qa_mm[$];
  int            qa_cyc[$];
  int            a_valid_cnt = 0;
  int            a_done_cyc = -1;
  logic          a_prev_done = 1'b0;
  logic [OW-1:0] qb_data[$];
  logic          qb_mm[$];
  int            qb_stab[$];
  int            b_stable = 0;
  logic [IW-1:0] b_prev_in = '0;
  logic          b_prev_valid = 1'b0;

  always @(negedge clk) begin
    if (a_valid) a_valid_cnt++;
    if (a_valid && a_ready) begin
      qa_data.push_back(a_data);
      qa_idx.push_back(int'(a_index));
      qa_mm.push_back(a_mm);
      qa_cyc.push_back(cyc);
    end
    if (a_done && !a_prev_done) a_done_cyc = cyc;
    a_prev_done = a_done;
    if (b_valid) begin
      qb_data.push_back(b_data);
      qb_mm.push_back(b_mm);
    end
    if (b_valid && !b_prev_valid) qb_stab.push_back(b_stable);
    if (b_dut_in != b_prev_in) b_stable = 1;
    else b_stable++;
    b_prev_in    = b_dut_in;
    b_prev_valid = b_valid;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_sig(input int n);
    logic [31:0] s;
    s = 32'h0;
    for (int i = 0; i < n; i++)
      s = {s[30:0], 1'b0} ^ (s[31] ? 32'h04C1_1DB7 : 32'h0) ^ exp_lo[i];
    return s;
  endfunction

  int a_c0 = 0;

  task automatic clear_mon();
    qa_data.delete(); qa_idx.delete(); qa_mm.delete(); qa_cyc.delete();
    a_valid_cnt = 0;
    a_done_cyc  = -1;
  endtask

  task automatic run_a(input int n);
    @(posedge clk); #1;
    a_num = CW'(n); a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    a_c0 = cyc;
  endtask

  task automatic wait_a_done(input string t);
    int k;
    for (k = 0; k < 300; k++) begin
      if (a_done) break;
      @(posedge clk); #1;
    end
    chk({t, "_timeout"}, 64'(a_done), 64'd1);
    @(negedge clk); #1;
  endtask

  task automatic check_a_results(input string t, input int n, input int mm_at);
    chk({t, "_count"}, 64'(qa_data.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      if (i < qa_data.size()) begin
        chk($sformatf("%s_idx%0d", t, i), 64'(qa_idx[i]), 64'(i));
        chk($sformatf("%s_data%0d", t, i), 64'(qa_data[i]), 64'(exp_lo[i]));
        chk($sformatf("%s_mm%0d", t, i), 64'(qa_mm[i]), 64'(i == mm_at));
      end
    end
  endtask

  initial begin
    logic [OW-1:0] f_data;
    logic [AW-1:0] f_idx, f_addr;
    logic [IW-1:0] f_in;
    int k;

    stim[0] = 41'h1_0000_0001; exp_lo[0] = 32'h0000_0001;
    stim[1] = 41'h0_8000_0000; exp_lo[1] = 32'h8000_0000;
    stim[2] = 41'h1_A5A5_5A5A; exp_lo[2] = 32'hA5A5_5A5A;
    stim[3] = 41'h0_FFFF_FFFF; exp_lo[3] = 32'hFFFF_FFFF;
    stim[4] = 41'h1_1234_5678; exp_lo[4] = 32'h1234_5678;
    stim[5] = 41'h0_0F0F_F0F0; exp_lo[5] = 32'h0F0F_F0F0;
    stim[6] = 41'h1_DEAD_BEEF; exp_lo[6] = 32'hDEAD_BEEF;
    stim[7] = 41'h0_CAFE_F00D; exp_lo[7] = 32'hCAFE_F00D;
    for (int i = 0; i < DP; i++) expw[i] = exp_lo[i];

    // reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_valid", 64'(a_valid), 64'd0);
    chk("rst_busy", 64'(a_busy), 64'd0);
    chk("rst_done", 64'(a_done), 64'd0);
    chk("rst_err", 64'(a_err), 64'd0);
    chk("rst_sig", 64'(a_sig), 64'd0);
    chk("rst_dut_in", 64'(a_dut_in), 64'd0);
    chk("rst_addr", 64'(a_mem_addr), 64'd0);

    // four matching vectors, ready held high
    clear_mon();
    run_a(4);
    chk("t1_busy", 64'(a_busy), 64'd1);
    wait_a_done("t1");
    check_a_results("t1", 4, -1);
    if (qa_cyc.size() == 4) begin
      chk("t1_first_valid", 64'(qa_cyc[0] - a_c0), 64'd2);
      for (int i = 1; i < 4; i++)
        chk($sformatf("t1_gap%0d", i), 64'(qa_cyc[i] - qa_cyc[i-1]), 64'd3);
      chk("t1_done_cyc", 64'(a_done_cyc - qa_cyc[3]), 64'd1);
    end
    chk("t1_valid_cycles", 64'(a_valid_cnt), 64'd4);
    chk("t1_err", 64'(a_err), 64'd0);
    chk("t1_sig", 64'(a_sig), 64'(ref_sig(4)));
    chk("t1_busy_end", 64'(a_busy), 64'd0);
    chk("t1_dut_in_hold", 64'(a_dut_in), 64'(stim[3]));

    // vector 2 expected word with bit 5 flipped
    expw[2] = exp_lo[2] ^ 32'h0000_0020;
    clear_mon();
    run_a(4);
    wait_a_done("t2");
    check_a_results("t2", 4, 2);
    chk("t2_err", 64'(a_err), 64'd1);
    chk("t2_sig", 64'(a_sig), 64'(ref_sig(4)));
    expw[2] = exp_lo[2];

    // backpressure during EMIT of vector 1
    clear_mon();
    run_a(4);
    for (k = 0; k < 50; k++) begin
      if (a_valid && a_index == 3'd1) break;
      @(posedge clk); #1;
    end
    chk("t4_reach_emit1", 64'(a_valid && a_index == 3'd1), 64'd1);
    a_ready = 1'b0;
    f_data = a_data; f_idx = a_index; f_addr = a_mem_addr; f_in = a_dut_in;
    repeat (10) begin @(posedge clk); #1; end
    chk("t4_valid_held", 64'(a_valid), 64'd1);
    chk("t4_data_frozen", 64'(a_data), 64'(exp_lo[1]));
    chk("t4_data_same", 64'(a_data), 64'(f_data));
    chk("t4_idx_frozen", 64'(a_index), 64'(f_idx));
    chk("t4_addr_frozen", 64'(a_mem_addr), 64'd1);
    chk("t4_addr_same", 64'(a_mem_addr), 64'(f_addr));
    chk("t4_dut_in_frozen", 64'(a_dut_in), 64'(f_in));
    a_ready = 1'b1;
    wait_a_done("t4");
    check_a_results("t4", 4, -1);
    chk("t4_sig", 64'(a_sig), 64'(ref_sig(4)));

    // zero-length run
    clear_mon();
    run_a(0);
    chk("t5_done_next", 64'(a_done), 64'd1);
    chk("t5_busy", 64'(a_busy), 64'd0);
    repeat (4) begin @(posedge clk); #1; end
    chk("t5_no_valid", 64'(a_valid_cnt), 64'd0);
    chk("t5_sig_clear", 64'(a_sig), 64'd0);
    chk("t5_err", 64'(a_err), 64'd0);

    // oversize request is clamped to DEPTH
    clear_mon();
    run_a(DP + 5);
    wait_a_done("t6");
    check_a_results("t6", DP, -1);
    chk("t6_valid_cycles", 64'(a_valid_cnt), 64'(DP));

    // reset mid-run, then a clean two-vector run with an ignored busy start
    expw[1] = exp_lo[1] ^ 32'h0000_0001;
    clear_mon();
    run_a(4);
    for (k = 0; k < 50; k++) begin
      if (a_dut_in == stim[2] && a_busy && !a_valid) break;
      @(posedge clk); #1;
    end
    chk("t7_reach_apply2", 64'(a_dut_in == stim[2] && a_busy && !a_valid), 64'd1);
    chk("t7_err_before", 64'(a_err), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t7_rst_valid", 64'(a_valid), 64'd0);
    chk("t7_rst_busy", 64'(a_busy), 64'd0);
    chk("t7_rst_err", 64'(a_err), 64'd0);
    chk("t7_rst_sig", 64'(a_sig), 64'd0);
    chk("t7_rst_dut_in", 64'(a_dut_in), 64'd0);
    chk("t7_rst_addr", 64'(a_mem_addr), 64'd0);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("t7_partial_count", 64'(qa_data.size()), 64'd2);
    expw[1] = exp_lo[1];
    expw[0] = exp_lo[0] ^ 32'h0000_0001;
    clear_mon();
    run_a(2);
    @(posedge clk); #1;
    a_num = 4'd5; a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    wait_a_done("t7");
    repeat (3) begin @(posedge clk); #1; end
    check_a_results("t7", 2, 0);
    chk("t7_err", 64'(a_err), 64'd1);
    chk("t7_sig", 64'(a_sig), 64'(ref_sig(2)));
    chk("t7_busy_end", 64'(a_busy), 64'd0);
    expw[0] = exp_lo[0];

    // settle 3 against a 2-cycle-delay DUT
    @(posedge clk); #1;
    b_num = 4'd4; b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    for (k = 0; k < 300; k++) begin
      if (b_done) break;
      @(posedge clk); #1;
    end
    chk("t3_timeout", 64'(b_done), 64'd1);
    @(negedge clk); #1;
    chk("t3_count", 64'(qb_data.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < qb_data.size()) begin
        chk($sformatf("t3_data%0d", i), 64'(qb_data[i]), 64'(exp_lo[i]));
        chk($sformatf("t3_mm%0d", i), 64'(qb_mm[i]), 64'd0);
      end
      if (i < qb_stab.size())
        chk($sformatf("t3_stable%0d", i), 64'(qb_stab[i]), 64'd3);
    end
    chk("t3_err", 64'(b_err), 64'd0);
    chk("t3_sig", 64'(b_sig), 64'(ref_sig(4)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
